// File: rtl/alu_seq_pkg.sv
// Shared defaults and FSM state encoding for the ALU command sequencer.
package alu_seq_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int OP_W_DEF   = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_RESP  = ST_RESP
    } state_t;

endpackage

// File: rtl/alu_seq_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit so full/empty
// are told apart by the MSB compare.
module alu_seq_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer advance on accepted push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage write; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command queue and issue/capture FSM in front of a combinational ALU.
// Optional operand chaining from the last result is enabled by ALU_SEQ_CHAIN_EN.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int OP_W       = OP_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
`ifdef ALU_SEQ_CHAIN_EN
    input  logic              cmd_chain,
`endif
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W:0]   alu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W:0]   rsp_data,
    output logic [OP_W-1:0]   rsp_op,
    output logic              busy
);

`ifdef ALU_SEQ_CHAIN_EN
    localparam int CMD_W = OP_W + 2*DATA_W + 1;
`else
    localparam int CMD_W = OP_W + 2*DATA_W;
`endif
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ne;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [OP_W-1:0]   r_alu_op;
    logic              r_rsp_valid;
    logic [DATA_W:0]   r_rsp_data;
    logic [OP_W-1:0]   r_rsp_op;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_capture;
    logic              w_last;
    logic [CMD_W-1:0]  w_fifo_din;
    logic [CMD_W-1:0]  w_fifo_dout;
    logic [DATA_W-1:0] w_head_a;
`ifdef ALU_SEQ_CHAIN_EN
    logic [DATA_W-1:0] r_acc_q;
`endif

    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && !w_full;
    assign w_last    = (r_cnt == CNT_W'(SETTLE_CYC - 1));
`ifdef ALU_SEQ_CHAIN_EN
    assign w_fifo_din = {cmd_chain, cmd_op, cmd_a, cmd_b};
    assign w_head_a   = w_fifo_dout[CMD_W-1] ? r_acc_q : w_fifo_dout[2*DATA_W-1:DATA_W];
`else
    assign w_fifo_din = {cmd_op, cmd_a, cmd_b};
    assign w_head_a   = w_fifo_dout[2*DATA_W-1:DATA_W];
`endif

    alu_seq_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_fifo_din),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and pop/capture strobes; IDLE waits on the registered non-empty flag.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_ne && !w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = S_ISSUE;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (w_last) begin
                    w_capture    = 1'b1;
                    w_next_state = S_RESP;
                end else begin
                    w_next_state = S_ISSUE;
                end
            end
            S_RESP: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_RESP;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Operand issue, settle counter and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ne        <= 1'b0;
            r_cnt       <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_op    <= '0;
        end else begin
            r_ne <= !w_empty;
            if (w_pop) begin
                r_alu_a  <= w_head_a;
                r_alu_b  <= w_fifo_dout[DATA_W-1:0];
                r_alu_op <= w_fifo_dout[OP_W+2*DATA_W-1:2*DATA_W];
                r_cnt    <= '0;
            end else if ((r_state == S_ISSUE) && !w_last) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_capture) begin
                r_rsp_data  <= alu_out;
                r_rsp_op    <= r_alu_op;
                r_rsp_valid <= 1'b1;
            end else if (r_rsp_valid && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_SEQ_CHAIN_EN
    // Accumulator holding the low bits of the most recent result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_q <= '0;
        end else if (w_capture) begin
            r_acc_q <= alu_out[DATA_W-1:0];
        end
    end
`endif

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_op    = r_rsp_op;
    assign busy      = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with an adder ALU stub and an in-order
// response model; chaining checks compile in when ALU_SEQ_CHAIN_EN is defined.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [3:0] cmd_a = 4'd0;
    logic [3:0] cmd_b = 4'd0;
`ifdef ALU_SEQ_CHAIN_EN
    logic       cmd_chain = 1'b0;
`endif
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [4:0] alu_out;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [4:0] rsp_data;
    logic [2:0] rsp_op;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Expected responses in push order: {op, result}.
    logic [7:0] exp_q[$];
    logic [4:0] last_res = 5'd0;

    always #5 clk = ~clk;

    assign alu_out = {1'b0, alu_a} + {1'b0, alu_b};

    alu_op_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
`ifdef ALU_SEQ_CHAIN_EN
        .cmd_chain (cmd_chain),
`endif
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_op    (rsp_op),
        .busy      (busy)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: results come back in push order, so a chained operand is the
    // previous pushed command's result.
    task automatic model_push(input logic [2:0] op, input logic [3:0] a,
                              input logic [3:0] b, input logic chain);
        logic [3:0] a_eff;
        logic [4:0] res;
        a_eff = chain ? last_res[3:0] : a;
        res = 5'(a_eff) + 5'(b);
        last_res = res;
        exp_q.push_back({op, res});
    endtask

    task automatic drive_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
    endtask

    function automatic logic cur_chain();
`ifdef ALU_SEQ_CHAIN_EN
        return cmd_chain;
`else
        return 1'b0;
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (alu_a !== 4'd0 || alu_b !== 4'd0 || alu_op !== 3'd0 || rsp_valid !== 1'b0 ||
            busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_data !== 5'd0 || rsp_op !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: a=%h b=%h op=%h rv=%b busy=%b rdy=%b want 0 0 0 0 0 1",
                     alu_a, alu_b, alu_op, rsp_valid, busy, cmd_ready);
        end
        rst_n = 1'b1;
        last_res = 5'd0;
        step();
    endtask

    task automatic test_latency();
        logic [7:0] e;
        rsp_ready = 1'b1;
        drive_cmd(3'b000, 4'hF, 4'hF);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL lat_ready: got %b want 1", cmd_ready);
        end
        model_push(cmd_op, cmd_a, cmd_b, cur_chain());
        step();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL lat_early: rsp_valid=%b at edge N+%0d want 0", rsp_valid, k - 1);
            end
            step();
        end
        checks++;
        if (alu_a !== 4'hF || alu_b !== 4'hF || alu_op !== 3'b000) begin
            errors++;
            $display("FAIL lat_operands: a=%h b=%h op=%h want f f 0", alu_a, alu_b, alu_op);
        end
        e = exp_q.pop_front();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 5'b11110 || rsp_op !== 3'b000 || e[4:0] !== 5'b11110) begin
            errors++;
            $display("FAIL lat_resp: rv=%b data=%b op=%b want 1 11110 000", rsp_valid, rsp_data, rsp_op);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL lat_drain: rv=%b busy=%b want 0 0", rsp_valid, busy);
        end
    endtask

    // Fill with responses stalled: one in flight plus four queued.
    task automatic fill(input int want, output int accepted);
        accepted = 0;
        rsp_ready = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (accepted < want) begin
                drive_cmd(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end else begin
                cmd_valid = 1'b0;
            end
            #1;
            if (cmd_valid && cmd_ready) begin
                model_push(cmd_op, cmd_a, cmd_b, cur_chain());
                accepted++;
            end
            step();
        end
    endtask

    task automatic test_capacity_and_hold();
        int acc;
        int got;
        logic [7:0] e;
        fill(6, acc);
        checks++;
        if (acc !== 5) begin
            errors++;
            $display("FAIL cap_accepted: got %0d want 5", acc);
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL cap_ready: got %b want 0", cmd_ready);
        end
        cmd_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            e = exp_q[0];
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== e[4:0] || rsp_op !== e[7:5]) begin
                errors++;
                $display("FAIL hold_stable cyc%0d: rv=%b data=%h op=%h want 1 %h %h",
                         k, rsp_valid, rsp_data, rsp_op, e[4:0], e[7:5]);
            end
            step();
        end
        rsp_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
            if (rsp_valid) begin
                e = exp_q.pop_front();
                got++;
                checks++;
                if (rsp_data !== e[4:0] || rsp_op !== e[7:5]) begin
                    errors++;
                    $display("FAIL order_resp%0d: data=%h op=%h want %h %h",
                             got, rsp_data, rsp_op, e[4:0], e[7:5]);
                end
            end
            step();
        end
        checks++;
        if (got !== 5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL order_count: got %0d busy=%b want 5 0", got, busy);
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        fill(5, acc);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        step();
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre: busy=%b rv=%b want 1 0", busy, rsp_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_async: busy=%b rv=%b rdy=%b want 0 0 1", busy, rsp_valid, cmd_ready);
        end
        step();
        rst_n = 1'b1;
        exp_q.delete();
        last_res = 5'd0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL midrst_after cyc%0d: rv=%b busy=%b rdy=%b want 0 0 1",
                         k, rsp_valid, busy, cmd_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] e;
        for (int cyc = 0; cyc < 400; cyc++) begin
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_op = 3'($urandom_range(0, 7));
            cmd_a = 4'($urandom_range(0, 15));
            cmd_b = 4'($urandom_range(0, 15));
`ifdef ALU_SEQ_CHAIN_EN
            cmd_chain = 1'($urandom_range(0, 1));
`endif
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious: data=%h op=%h with nothing expected", rsp_data, rsp_op);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_data !== e[4:0] || rsp_op !== e[7:5]) begin
                        errors++;
                        $display("FAIL rand_resp cyc%0d: data=%h op=%h want %h %h",
                                 cyc, rsp_data, rsp_op, e[4:0], e[7:5]);
                    end
                end
            end
            if (cmd_valid && cmd_ready) begin
                model_push(cmd_op, cmd_a, cmd_b, cur_chain());
            end
            step();
        end
        cmd_valid = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
        cmd_chain = 1'b0;
`endif
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && (exp_q.size() != 0 || busy); cyc++) begin
            if (rsp_valid) begin
                e = exp_q.pop_front();
                checks++;
                if (rsp_data !== e[4:0] || rsp_op !== e[7:5]) begin
                    errors++;
                    $display("FAIL rand_drain: data=%h op=%h want %h %h", rsp_data, rsp_op, e[4:0], e[7:5]);
                end
            end
            step();
        end
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rand_final: left %0d busy=%b want 0 0", exp_q.size(), busy);
        end
    endtask

`ifdef ALU_SEQ_CHAIN_EN
    task automatic chain_one(input logic [3:0] a, input logic [3:0] b, input logic ch,
                             input logic [3:0] want_a, input logic [4:0] want_res);
        int cyc;
        rsp_ready = 1'b0;
        cmd_chain = ch;
        drive_cmd(3'b001, a, b);
        step();
        cmd_valid = 1'b0;
        cmd_chain = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            step();
            cyc++;
        end
        checks++;
        if (rsp_valid !== 1'b1 || alu_a !== want_a || rsp_data !== want_res) begin
            errors++;
            $display("FAIL chain: rv=%b alu_a=%h data=%h want 1 %h %h", rsp_valid, alu_a, rsp_data, want_a, want_res);
        end
        rsp_ready = 1'b1;
        step();
    endtask

    task automatic test_chain();
        chain_one(4'd3, 4'd2, 1'b0, 4'd3, 5'd5);
        chain_one(4'd0, 4'd1, 1'b1, 4'd5, 5'd6);
        last_res = 5'd6;
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_latency();
        test_capacity_and_hold();
        test_reset_mid();
`ifdef ALU_SEQ_CHAIN_EN
        test_chain();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
